shift_seq_param: RTL and testbench
==================================

Name: shift_seq_param

Overview:
- Parametrised sequential shifter; successor to the fixed 5-bit, shift-right-by-2 combinational shifter.
- Loads a WIDTH-bit operand and shifts it one bit position per clock for a run-time amount.
- Supports four modes: logical right, arithmetic right, logical left, rotate right.
- Uses a start/busy/done handshake; sits in the chapter-7 register/shifter examples as the datapath shift unit.

Parameters:
- WIDTH, 5, operand and result width in bits (≥2).
- AW, 3, width of the shift-amount input; amounts 0..2^AW-1 are legal.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a shift; sampled on the rising edge of clk.
- mode  input  2  00 = LSR, 01 = ASR, 10 = LSL, 11 = ROR; sampled with start.
- amount  input  AW  number of single-bit shifts; sampled with start.
- d  input  WIDTH  operand; sampled with start.
- q  output  WIDTH  working/result register.
- busy  output  1  high while shifting is in progress.
- done  output  1  one-cycle pulse; q holds the final result while done is high.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; q = 0; internal counter cnt = 0; latched mode = 00.
  - busy = 0; done = 0.
- FSM states: IDLE, SHIFT, DONE.
  - busy = (state == SHIFT); done = (state == DONE). Both decoded from registered state, no glitch paths.
- Accepting a request:
  - start is accepted only in IDLE or DONE, which allows back-to-back requests.
  - On the accept edge: q <= d; cnt <= amount; mode latched.
  - Next state = DONE if amount == 0, else SHIFT.
- SHIFT, on each edge:
  - q <= step(q, mode); cnt <= cnt - 1.
  - If cnt == 1, next state = DONE; else stay in SHIFT.
- DONE:
  - Lasts exactly one cycle, then goes to IDLE unless start is accepted on that edge.
- start while in SHIFT is ignored entirely; no queueing, the in-flight operation is unaffected.
- step() definitions:
  - LSR: {0, q[W-1:1]}
  - ASR: {q[W-1], q[W-1:1]}
  - LSL: {q[W-2:0], 0}
  - ROR: {q[0], q[W-1:1]}
- Latency: done is high in cycle amount+1 after the accept edge. amount == 0 gives done on the next cycle with q = d.
- amount ≥ WIDTH is legal; the result simply follows from repeated single-bit steps:
  - LSR/LSL yield 0.
  - ASR yields all copies of the sign bit.
  - ROR wraps modulo WIDTH.
- q holds its value in IDLE and after done until the next accepted start.
- rst asserted mid-SHIFT aborts immediately to reset values; no done pulse is produced.
- A new start on the same edge that done is high is accepted: q reloads, and done drops on the next cycle unless the new amount == 0.

Decomposition:
- Shared package/header shift_defs holds the mode constants MODE_LSR = 2'b00, MODE_ASR = 2'b01, MODE_LSL = 2'b10, MODE_ROR = 2'b11, and the state encodings IDLE/SHIFT/DONE.
- One combinational sub-module, shift_one_step (WIDTH param; inputs q and mode; output next q), implements step().
- The top level holds the FSM, counter and q register.

Test Plan:
- Reset mid-operation: WIDTH = 5; start d = 10110, LSR, amount = 3; assert rst after 1 shift cycle → q = 00000, busy = 0, done = 0 immediately; no done pulse follows.
- LSR: d = 10110, amount = 2 → busy for 2 cycles, done on the 3rd cycle after accept, q = 00101. Sweep d = 0..31 at amount = 2 and check q == d >> 2 every time.
- ASR and LSL: d = 10110, ASR, amount = 2 → q = 11101. Same d, LSL, amount = 2 → q = 11000.
- ROR and large amount: d = 10110, ROR, amount = 7 → q = 10101 (rotate by 2). LSR with amount = 7 → q = 00000.
- Zero amount: amount = 0, d = 01101 → done on the next cycle, busy never asserted, q = 01101.
- Handshake: start pulsed during SHIFT → ignored, original result unchanged. start asserted in the DONE cycle (d = 00011, LSL, amount = 1) → accepted, q = 00110 two cycles later.

Source files
------------

// File: rtl/shift_defs.sv
// Shared mode constants and FSM state encoding for the sequential shifter.
package shift_defs;

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;
    localparam logic [1:0] MODE_LSL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_one_step.sv
// Single-bit shift/rotate of a WIDTH-bit word in one of four modes.
module shift_one_step
    import shift_defs::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q_next_c
);

    always_comb begin
        q_next_c = q;
        case (mode)
            MODE_LSR: q_next_c = {1'b0, q[WIDTH-1:1]};
            MODE_ASR: q_next_c = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_LSL: q_next_c = {q[WIDTH-2:0], 1'b0};
            MODE_ROR: q_next_c = {q[0], q[WIDTH-1:1]};
            default:  q_next_c = q;
        endcase
    end

endmodule

// File: rtl/shift_seq_param.sv
// Sequential shifter: loads an operand on start, steps it one bit per clock
// for a run-time amount, then pulses done with the result held in q.
module shift_seq_param
    import shift_defs::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    amount,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    logic [AW-1:0]    cnt, cnt_n;
    logic [1:0]       mode_r, mode_n;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] q_step;

    shift_one_step #(.WIDTH(WIDTH)) u_step (
        .q        (q),
        .mode     (mode_r),
        .q_next_c (q_step)
    );

    // State, datapath and status flags; busy/done track the next state so
    // they are flops equal to the decode of the registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            q      <= '0;
            cnt    <= '0;
            mode_r <= MODE_LSR;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            q      <= q_n;
            cnt    <= cnt_n;
            mode_r <= mode_n;
            busy   <= (state_n == SHIFT);
            done   <= (state_n == DONE);
        end
    end

    // Next-state and datapath; start is honoured in IDLE and DONE only.
    always_comb begin
        state_n = state;
        q_n     = q;
        cnt_n   = cnt;
        mode_n  = mode_r;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    q_n     = d;
                    cnt_n   = amount;
                    mode_n  = mode;
                    state_n = (amount == '0) ? DONE : SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                q_n   = q_step;
                cnt_n = cnt - AW'(1);
                if (cnt == AW'(1)) begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_seq_param.sv
// Directed, table-driven bench for the sequential shifter (WIDTH=5, AW=3).
module tb_shift_seq_param;

    localparam logic [1:0] LSR = 2'b00;
    localparam logic [1:0] ASR = 2'b01;
    localparam logic [1:0] LSL = 2'b10;
    localparam logic [1:0] ROR = 2'b11;
    localparam int         BUDGET = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [2:0] amount;
    logic [4:0] d;
    logic [4:0] q;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] d;
        logic [1:0] mode;
        logic [2:0] amount;
        logic [4:0] exp_q;
    } vec_t;

    vec_t vecs [12];

    shift_seq_param #(.WIDTH(5), .AW(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .amount (amount),
        .d      (d),
        .q      (q),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue a request at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [4:0] dv, input logic [1:0] m, input logic [2:0] a);
        @(negedge clk);
        start  = 1'b1;
        d      = dv;
        mode   = m;
        amount = a;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Starting at cycle 1 after accept, sample each negedge until done or budget.
    task automatic wait_done(output int cycles, output int nbusy);
        cycles = 1;
        nbusy  = 0;
        while (1) begin
            if (busy) nbusy++;
            if (done || cycles >= BUDGET) break;
            @(negedge clk);
            cycles++;
        end
        check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_op(input vec_t v, input string name);
        int cycles, nbusy;
        issue(v.d, v.mode, v.amount);
        wait_done(cycles, nbusy);
        check({name, "_latency"}, 32'(cycles), 32'(v.amount) + 32'd1);
        check({name, "_busy_cycles"}, 32'(nbusy), 32'(v.amount));
        check({name, "_q"}, 32'(q), 32'(v.exp_q));
        @(negedge clk);
        check({name, "_done_drop"}, 32'(done), 32'd0);
        check({name, "_q_hold"}, 32'(q), 32'(v.exp_q));
    endtask

    initial begin
        int cycles, nbusy, seen_done;

        vecs[0]  = '{5'b10110, LSR, 3'd2, 5'b00101};
        vecs[1]  = '{5'b10110, ASR, 3'd2, 5'b11101};
        vecs[2]  = '{5'b10110, LSL, 3'd2, 5'b11000};
        vecs[3]  = '{5'b10110, ROR, 3'd7, 5'b10101};
        vecs[4]  = '{5'b10110, LSR, 3'd7, 5'b00000};
        vecs[5]  = '{5'b10110, LSL, 3'd7, 5'b00000};
        vecs[6]  = '{5'b10110, ASR, 3'd7, 5'b11111};
        vecs[7]  = '{5'b01101, ASR, 3'd3, 5'b00001};
        vecs[8]  = '{5'b01101, LSR, 3'd0, 5'b01101};
        vecs[9]  = '{5'b00001, ROR, 3'd1, 5'b10000};
        vecs[10] = '{5'b10110, ROR, 3'd5, 5'b10110};
        vecs[11] = '{5'b00011, LSL, 3'd1, 5'b00110};

        rst = 1'b1; start = 1'b0; mode = LSR; amount = '0; d = '0;
        #12;
        check("reset_q", 32'(q), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 32; i++) begin
            issue(5'(i), LSR, 3'd2);
            wait_done(cycles, nbusy);
            check($sformatf("sweep_lsr_%0d", i), 32'(q), 32'(i >> 2));
        end

        // Reset after one shift cycle aborts with no done pulse.
        issue(5'b10110, LSR, 3'd3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_q", 32'(q), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);

        // start during SHIFT is ignored.
        issue(5'b10110, LSR, 3'd3);
        start = 1'b1; d = 5'b11111; mode = LSL; amount = 3'd1;
        @(negedge clk);
        start = 1'b0;
        cycles = 2;
        while (!done && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
        end
        check("ignore_latency", 32'(cycles), 32'd4);
        check("ignore_q", 32'(q), 32'b00010);
        @(negedge clk);

        // start in the DONE cycle is accepted back-to-back.
        issue(5'b10110, LSR, 3'd2);
        wait_done(cycles, nbusy);
        start = 1'b1; d = 5'b00011; mode = LSL; amount = 3'd1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_drop", 32'(done), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_q", 32'(q), 32'b00110);

        // Zero-amount request in the DONE cycle keeps done high.
        start = 1'b1; d = 5'b01010; mode = ROR; amount = 3'd0;
        @(negedge clk);
        start = 1'b0;
        check("b2b_zero_done", 32'(done), 32'd1);
        check("b2b_zero_q", 32'(q), 32'b01010);
        @(negedge clk);
        check("b2b_zero_idle", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
